// File: rtl/hll_pkg.sv
// Shared types and helpers for the HyperLogLog DMA job sequencer.
//   hll_seq_state_t : sequencer FSM states
//   hll_job_t       : job descriptor, laid out to match s_axis_job_data
//   calc_burst_len  : bytes for the next burst. The result is capped by the
//                     remaining bytes and never crosses a max_burst boundary.
package hll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } hll_seq_state_t;

  // Field order puts tuples in the upper bits, matching the job bus:
  // [63:0] holds the address and [95:64] holds the tuple count.
  typedef struct packed {
    logic [31:0] tuples;
    logic [63:0] addr;
  } hll_job_t;

  // max_burst must be a power of two.
  function automatic logic [31:0] calc_burst_len(input logic [63:0] addr,
                                                 input logic [39:0] remaining,
                                                 input logic [31:0] max_burst);
    logic [63:0] room;
    room = 64'(max_burst) - (addr & (64'(max_burst) - 64'd1));
    if ({24'd0, remaining} < room) calc_burst_len = remaining[31:0];
    else                           calc_burst_len = room[31:0];
  endfunction

endpackage

// File: rtl/hll_dma_job_sequencer.sv
// Splits one HLL scan job into boundary-safe, length-capped DMA read commands.
// An outstanding-burst credit counter throttles the commands, and job_done
// pulses once every burst has completed.
// Ports:
//   user_clk, user_reset   : clock and synchronous active-high reset
//   s_axis_job_*           : job descriptor in ({tuples[95:64], addr[63:0]})
//   m_axis_dma_cmd_*       : registered DMA read command out (addr, len bytes)
//   s_dma_burst_done       : one pulse per completed burst
//   job_busy / job_done    : job in flight / one-cycle completion pulse
//   tuples_issued          : tuples covered by issued commands in this job
//   err_spurious_done      : sticky flag for a done pulse with nothing outstanding
module hll_dma_job_sequencer
  import hll_pkg::*;
#(
  parameter int unsigned TUPLE_BYTES     = 64,
  parameter int unsigned MAX_BURST_BYTES = 4096,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic        user_clk,
  input  logic        user_reset,
  input  logic        s_axis_job_valid,
  output logic        s_axis_job_ready,
  input  logic [95:0] s_axis_job_data,
  output logic        m_axis_dma_cmd_valid,
  input  logic        m_axis_dma_cmd_ready,
  output logic [63:0] m_axis_dma_cmd_addr,
  output logic [31:0] m_axis_dma_cmd_len,
  input  logic        s_dma_burst_done,
  output logic        job_busy,
  output logic        job_done,
  output logic [31:0] tuples_issued,
  output logic        err_spurious_done
);

  localparam int          TB_SH = $clog2(TUPLE_BYTES);
  localparam logic [31:0] MAXB  = 32'(MAX_BURST_BYTES);
  localparam logic [7:0]  MAXO  = 8'(MAX_OUTSTANDING);

  hll_seq_state_t state, state_n;
  hll_job_t       job;
  logic [63:0]    addr_q, addr_n;
  logic [39:0]    rem_q, rem_n;
  logic [31:0]    tup_q, tup_n, len_q, len_n;
  logic [7:0]     out_q, out_n;
  logic           ready_q, vld_q, vld_n, err_q, err_n;
  logic           job_hs, cmd_hs;

  assign job    = hll_job_t'(s_axis_job_data);
  assign job_hs = s_axis_job_valid & ready_q;
  assign cmd_hs = vld_q & m_axis_dma_cmd_ready;

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    rem_n   = rem_q;
    tup_n   = tup_q;
    out_n   = out_q;
    err_n   = err_q;

    // A handshake and a done pulse in the same cycle cancel out.
    if (cmd_hs && !s_dma_burst_done) out_n = out_q + 8'd1;
    else if (!cmd_hs && s_dma_burst_done) begin
      if (out_q == 8'd0) err_n = 1'b1;
      else               out_n = out_q - 8'd1;
    end

    case (state)
      ST_IDLE: if (job_hs) begin
        addr_n  = job.addr & ~64'(TUPLE_BYTES - 1);
        rem_n   = 40'(job.tuples) << TB_SH;
        tup_n   = '0;
        state_n = (job.tuples == 32'd0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: if (cmd_hs) begin
        addr_n = addr_q + 64'(len_q);
        rem_n  = rem_q - 40'(len_q);
        tup_n  = tup_q + (len_q >> TB_SH);
        if (rem_n == 40'd0) state_n = ST_DRAIN;
      end
      ST_DRAIN: if (out_q == 8'd0) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    // Command outputs are built from the next-cycle state so they can be
    // registered and still appear one cycle after the event that causes them.
    len_n = calc_burst_len(addr_n, rem_n, MAXB);
    vld_n = (state_n == ST_ISSUE) && (out_n < MAXO);
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      tup_q   <= '0;
      len_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      rem_q   <= rem_n;
      tup_q   <= tup_n;
      len_q   <= (state_n == ST_ISSUE) ? len_n : '0;
      out_q   <= out_n;
      ready_q <= (state_n == ST_IDLE);
      vld_q   <= vld_n;
      err_q   <= err_n;
    end
  end

  assign s_axis_job_ready     = ready_q;
  assign m_axis_dma_cmd_valid = vld_q;
  assign m_axis_dma_cmd_addr  = addr_q;
  assign m_axis_dma_cmd_len   = len_q;
  assign job_busy             = (state != ST_IDLE);
  assign job_done             = (state == ST_DONE);
  assign tuples_issued        = tup_q;
  assign err_spurious_done    = err_q;

endmodule
